vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 640x480 hsync/vsync pair.

---
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. A single pixel-clock-enabled counter
//   pair (h, v) drives aligned x/y coordinates, data-enable, h/v sync, line and
//   frame strobes, and a completed-frame counter. RGB from the image generator
//   is masked to black outside the active area.
//
//   Optional feature: define VGA_TIMING_TESTPAT_EN to build in an eight-bar
//   colour test pattern selected by i_tp_sel. Without the macro i_tp_sel is
//   ignored and no divider is built.
//
// Ports
//   i_clk          system clock, all state on rising edge
//   i_rst_n        asynchronous reset, active-low
//   i_pix_ce       pixel enable; counters advance only when 1
//   i_tp_sel       select built-in test pattern (macro builds only)
//   i_rgb[2:0]     {r,g,b} for the pixel currently shown on o_x/o_y
//   o_x/o_y        horizontal / vertical count
//   o_de           active-area flag
//   o_hsync/o_vsync sync outputs, active level per H_POL / V_POL
//   o_line_start   one-clock pulse when o_x becomes 0
//   o_frame_start  one-clock pulse when (o_x,o_y) becomes (0,0)
//   o_frame        completed-frame counter, wraps
//   o_rgb[2:0]     masked colour to DAC pins
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int FRAME_W  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_ce,
    input  logic               i_tp_sel,
    input  logic [2:0]         i_rgb,
    output logic [CW-1:0]      o_x,
    output logic [CW-1:0]      o_y,
    output logic               o_de,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame,
    output logic [2:0]         o_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL >= 2**CW || V_TOTAL >= 2**CW) begin : g_cw_too_small
            $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
        end
    endgenerate

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON  = (H_POL != 0);
    localparam logic          VS_ON  = (V_POL != 0);

    logic [CW-1:0]      r_h_cnt;
    logic [CW-1:0]      r_v_cnt;
    logic               r_de;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame;

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [CW-1:0]      w_h_nxt;
    logic [CW-1:0]      w_v_nxt;
    logic [2:0]         w_colour;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    // v only moves on the h wrap, so vsync derived from w_v_nxt can only
    // change on the edge where h becomes 0.
    assign w_v_nxt  = !w_h_wrap ? r_v_cnt : (w_v_wrap ? '0 : r_v_cnt + 1'b1);

    // All flags are registered from the next count on the same edge the count
    // itself updates, so x/y, de, syncs and strobes carry zero relative skew.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_cnt       <= H_LAST;
            r_v_cnt       <= V_LAST;
            r_de          <= 1'b0;
            r_hsync       <= !HS_ON;
            r_vsync       <= !VS_ON;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame       <= '0;
        end else begin
            // strobes are one i_clk wide even when i_pix_ce is held high
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_pix_ce) begin
                r_h_cnt       <= w_h_nxt;
                r_v_cnt       <= w_v_nxt;
                r_de          <= (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
                r_hsync       <= ((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END)) ? HS_ON : !HS_ON;
                r_vsync       <= ((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END)) ? VS_ON : !VS_ON;
                r_line_start  <= w_h_wrap;
                r_frame_start <= w_h_wrap && w_v_wrap;
                if (w_h_wrap && w_v_wrap) begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

`ifdef VGA_TIMING_TESTPAT_EN
    // Eight equal-width bars across the active line; x beyond the last bar
    // clamps to bar 7 (the guard keeps tiny rasters from dividing by zero).
    localparam int            BAR_PIX = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CW-1:0] BAR_DIV = CW'(BAR_PIX);
    localparam logic [CW-1:0] BAR_MAX = CW'(7);

    logic [CW-1:0] w_bar_q;
    logic [2:0]    w_bar;

    assign w_bar_q  = r_h_cnt / BAR_DIV;
    assign w_bar    = (w_bar_q > BAR_MAX) ? 3'd7 : w_bar_q[2:0];
    assign w_colour = i_tp_sel ? ~w_bar : i_rgb;
`else
    logic w_unused_tp_sel;

    assign w_unused_tp_sel = i_tp_sel;
    assign w_colour        = i_rgb;
`endif

    assign o_x           = r_h_cnt;
    assign o_y           = r_v_cnt;
    assign o_de          = r_de;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_frame       = r_frame;
    assign o_rgb         = r_de ? w_colour : 3'b000;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int S_HT = 12;
    localparam int S_VT = 7;
    localparam int D_HT = 800;
    localparam int D_VT = 525;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce    = 1'b0;
    logic        tp_d  = 1'b1;
    logic        tp_s  = 1'b0;
    logic [2:0]  rgb   = 3'b000;

    logic [11:0] s_x, s_y, d_x, d_y;
    logic        s_de, s_hs, s_vs, s_ls, s_fs;
    logic        d_de, d_hs, d_vs, d_ls, d_fs;
    logic [7:0]  s_frame, d_frame;
    logic [2:0]  s_rgb, d_rgb;

    // small 12x7 raster with positive syncs
    vga_timing_gen #(
        .H_POL(1), .V_POL(1),
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_ce(ce), .i_tp_sel(tp_s), .i_rgb(rgb),
        .o_x(s_x), .o_y(s_y), .o_de(s_de), .o_hsync(s_hs), .o_vsync(s_vs),
        .o_line_start(s_ls), .o_frame_start(s_fs), .o_frame(s_frame), .o_rgb(s_rgb)
    );

    // default 640x480 timing
    vga_timing_gen u_dflt (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_ce(ce), .i_tp_sel(tp_d), .i_rgb(rgb),
        .o_x(d_x), .o_y(d_y), .o_de(d_de), .o_hsync(d_hs), .o_vsync(d_vs),
        .o_line_start(d_ls), .o_frame_start(d_fs), .o_frame(d_frame), .o_rgb(d_rgb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int sx, sy, sf, dx, dy, df;
    bit sls, sfs, dls, dfs;
    int cyc = 0;
    int ls_per = 0, fs_per = 0;
    int last_ls = -1, last_fs = -1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sx = S_HT - 1; sy = S_VT - 1; sf = 0; sls = 0; sfs = 0;
        dx = D_HT - 1; dy = D_VT - 1; df = 0; dls = 0; dfs = 0;
    endtask

    task automatic model_adv();
        if (sx == S_HT - 1) begin
            sx = 0;
            sy = (sy == S_VT - 1) ? 0 : sy + 1;
        end else sx = sx + 1;
        sls = (sx == 0);
        sfs = sls && (sy == 0);
        if (sfs) sf = (sf + 1) % 256;
        if (dx == D_HT - 1) begin
            dx = 0;
            dy = (dy == D_VT - 1) ? 0 : dy + 1;
        end else dx = dx + 1;
        dls = (dx == 0);
        dfs = dls && (dy == 0);
        if (dfs) df = (df + 1) % 256;
    endtask

    task automatic compare_all();
        bit   sde, dde;
        int   bi;
        logic [2:0] dcol;
        sde = (sx < 8) && (sy < 4);
        dde = (dx < 640) && (dy < 480);
        check("s_x", s_x, sx);
        check("s_y", s_y, sy);
        check("s_de", s_de, sde);
        check("s_hsync", s_hs, (sx == 9 || sx == 10) ? 1 : 0);
        check("s_vsync", s_vs, (sy == 5) ? 1 : 0);
        check("s_line_start", s_ls, sls);
        check("s_frame_start", s_fs, sfs);
        check("s_frame", s_frame, sf);
        check("s_rgb", s_rgb, sde ? rgb : 3'b000);
        check("d_x", d_x, dx);
        check("d_y", d_y, dy);
        check("d_de", d_de, dde);
        check("d_hsync", d_hs, (dx >= 656 && dx <= 751) ? 0 : 1);
        check("d_vsync", d_vs, (dy == 490 || dy == 491) ? 0 : 1);
        check("d_line_start", d_ls, dls);
        check("d_frame_start", d_fs, dfs);
        check("d_frame", d_frame, df);
`ifdef VGA_TIMING_TESTPAT_EN
        bi = dx / 80;
        if (bi > 7) bi = 7;
        dcol = 3'(7 - bi);
`else
        bi = 0;
        dcol = rgb;
`endif
        check("d_rgb", d_rgb, dde ? dcol : 3'b000);
    endtask

    // called at a negedge; drives one clock and checks at the next negedge
    task automatic tick(input logic ce_v);
        ce  = ce_v;
        rgb = 3'($urandom);
        @(posedge clk);
        cyc++;
        if (rst_n && ce_v) model_adv();
        else begin
            sls = 0; sfs = 0; dls = 0; dfs = 0;
        end
        @(negedge clk);
        compare_all();
        if (s_ls) begin
            if (last_ls >= 0 && ls_per > 0) check("line_period", cyc - last_ls, ls_per);
            last_ls = cyc;
        end
        if (s_fs) begin
            if (last_fs >= 0 && fs_per > 0) check("frame_period", cyc - last_fs, fs_per);
            last_fs = cyc;
        end
    endtask

    task automatic set_period(input int lp, input int fp);
        ls_per = lp; fs_per = fp; last_ls = -1; last_fs = -1;
    endtask

    initial begin
        bit wrapped;
        bit found;
        model_reset();
        rst_n = 1'b0;
        ce    = 1'b0;
        repeat (3) @(negedge clk);
        compare_all();
        check("rst_s_x", s_x, 11);
        check("rst_s_y", s_y, 6);
        check("rst_s_hsync", s_hs, 0);
        check("rst_d_hsync", d_hs, 1);
        check("rst_d_vsync", d_vs, 1);

        // first enabled pixel after release lands on (0,0) and counts a frame
        rst_n = 1'b1;
        tick(1'b1);
        check("first_x", s_x, 0);
        check("first_de", s_de, 1);
        check("first_fs", s_fs, 1);
        check("first_frame", s_frame, 1);
        check("first_d_frame", d_frame, 1);

        // continuous enable: covers the whole first default line incl. hsync and bars
        set_period(12, 84);
        repeat (900) tick(1'b1);

        // enable every other clock: periods double, strobes stay one clock
        set_period(24, 168);
        repeat (336) begin
            tick(1'b1);
            tick(1'b0);
        end

        // run on until the 8-bit frame counter rolls over
        set_period(12, 84);
        wrapped = 0;
        for (int i = 0; i < 25000 && !wrapped; i++) begin
            tick(1'b1);
            if (sfs && sf == 0) begin
                wrapped = 1;
                check("frame_wrap", s_frame, 0);
            end
        end
        if (!wrapped) check("frame_wrap_timeout", 0, 1);

        // asynchronous reset in the middle of a frame
        set_period(0, 0);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(1'b1);
            if (sx == 5 && sy == 3) found = 1;
        end
        if (!found) check("seek_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_s_x", s_x, 11);
        check("async_s_de", s_de, 0);
        repeat (3) tick(1'b1);
        rst_n = 1'b1;
        tick(1'b1);
        check("rel_x", s_x, 0);
        check("rel_y", s_y, 0);
        check("rel_fs", s_fs, 1);
        check("rel_frame", s_frame, 1);
        repeat (20) tick(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
